// File: rtl/led_fade_ctrl.sv
// led_fade_ctrl: period-synchronous LED brightness ramp controller driving a downstream PWM stage.
// Optional breathe mode (BR_UP/BR_DOWN) is compiled only when LED_FADE_BREATHE_EN is defined.
module led_fade_ctrl #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [10:0]       cmd_target,
    input  logic [STEP_W-1:0] cmd_step,
    input  logic              cmd_mode,
    output logic              pwm_en,
    output logic [10:0]       dutycycle,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {
        IDLE,
`ifdef LED_FADE_BREATHE_EN
        BR_UP,
        BR_DOWN,
`endif
        RAMP
    } state_t;

    localparam int W = (STEP_W > 11 ? STEP_W : 11) + 1;

    state_t              state, state_n;
    logic [10:0]         level, level_n, period_cnt, target, goal, moved;
    logic [STEP_W-1:0]   step;
    logic                done_n, accept, tick;
    logic [W-1:0]        lv_w, goal_w, step_w, sum_w;

    assign accept = cmd_valid && cmd_ready;
    // A tick is every cycle while the PWM is off, otherwise the last cycle of a PWM period.
    assign tick   = !pwm_en || &period_cnt;

`ifdef LED_FADE_BREATHE_EN
    assign goal = state == BR_DOWN ? 11'd0 : target;
`else
    logic unused_mode;
    assign unused_mode = cmd_mode;
    assign goal = target;
`endif

    // Wide intermediates so level +/- step saturates at goal instead of wrapping.
    assign lv_w   = W'(level);
    assign goal_w = W'(goal);
    assign step_w = W'(step);
    assign sum_w  = lv_w + step_w;
    assign moved  = step == '0 ? goal :
                    level < goal ? (sum_w > goal_w ? goal : sum_w[10:0]) :
                    level > goal ? (step_w >= lv_w - goal_w ? goal : 11'(lv_w - step_w)) :
                    level;

    always_comb begin
        state_n = state;
        level_n = level;
        done_n  = 1'b0;
        if (accept) begin
            state_n = cmd_target == level ? IDLE : RAMP;
            done_n  = cmd_target == level;
`ifdef LED_FADE_BREATHE_EN
            if (cmd_mode && cmd_target != 11'd0) begin
                state_n = BR_UP;
                done_n  = 1'b0;
            end
`endif
        end else if (tick && state != IDLE) begin
            level_n = moved;
            if (moved == goal) begin
                done_n  = state == RAMP;
`ifdef LED_FADE_BREATHE_EN
                state_n = state == RAMP ? IDLE : state == BR_UP ? BR_DOWN : BR_UP;
`else
                state_n = IDLE;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            level      <= '0;
            period_cnt <= '0;
            target     <= '0;
            step       <= '0;
            pwm_en     <= 1'b0;
            dutycycle  <= 11'h7FF;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_ready  <= 1'b0;
        end else begin
            state      <= state_n;
            level      <= level_n;
            period_cnt <= pwm_en ? period_cnt + 11'd1 : 11'd0;
            if (accept) begin
                target <= cmd_target;
                step   <= cmd_step;
            end
            pwm_en     <= level_n != 11'd0;
            dutycycle  <= level_n == 11'd0 ? 11'h7FF : 11'd0 - level_n;
            busy       <= state_n != IDLE;
            done       <= done_n;
            cmd_ready  <= state_n != RAMP;
        end
    end
endmodule

// File: doc/led_fade_ctrl.md
LED_FADE_CTRL -- requirements
Module: led_fade_ctrl

Interface
REQ-001 SHALL have parameter STEP_W, default 8, width of the per-period step size.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst, input, 1, a synchronous active-high reset sampled on the rising edge of clk.
REQ-004 SHALL have port cmd_valid, input, 1, command request.
REQ-005 SHALL have port cmd_ready, output, 1, command accept; a transfer occurs when cmd_valid and cmd_ready are both 1 on a clk edge.
REQ-006 SHALL have port cmd_target, input, 11, target brightness level (0 = off, 2047 = maximum).
REQ-007 SHALL have port cmd_step, input, STEP_W, level change per update tick (0 = jump).
REQ-008 SHALL have port cmd_mode, input, 1, 0 = ramp to target, 1 = breathe.
REQ-009 SHALL have port pwm_en, output, 1, enable to the downstream PWM stage.
REQ-010 SHALL have port dutycycle, output, 11, compare threshold for the downstream PWM stage.
REQ-011 SHALL have port busy, output, 1, high while in any state other than IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when a ramp reaches its target.

Function
REQ-013 SHALL hold an 11-bit register level and drive all outputs from registers.
REQ-014 SHALL drive pwm_en=0 and dutycycle=11'h7FF when level==0.
REQ-015 SHALL drive pwm_en=1 and dutycycle=2048-level (11-bit two's complement of level) when level!=0, so the downstream output is high for exactly level cycles per 2048.
REQ-016 SHALL keep an 11-bit period_cnt that clears whenever pwm_en==0 and increments by 1 per cycle, wrapping 2047->0, whenever pwm_en==1, mirroring the downstream counter.
REQ-017 SHALL assert an internal tick when pwm_en==0, or when pwm_en==1 and period_cnt==2047; level SHALL change only on tick, so a new duty applies at a period boundary.
REQ-018 SHALL implement states IDLE, RAMP, BR_UP and BR_DOWN.
REQ-019 SHALL drive cmd_ready=1 in IDLE, BR_UP and BR_DOWN, and cmd_ready=0 in RAMP.
REQ-020 SHALL, on command accept, latch target and step and go to RAMP (mode 0, or mode 1 with target 0) or BR_UP (mode 1 with target !=0).
REQ-021 SHALL NOT use a tick that falls in the accept cycle for a step; the first step occurs on the next tick.
REQ-022 SHALL, in RAMP on tick, set level=min(level+step,target) if level<target, and level=max(level-step,target) if level>target, using 12-bit intermediates with no wrap.
REQ-023 SHALL, with step==0, set level=target on the first tick.
REQ-024 SHALL, in RAMP when level equals target after a tick (or at accept), go to IDLE and pulse done for one cycle.
REQ-025 SHALL, in BR_UP, ramp toward target and enter BR_DOWN on reaching it, then ramp toward 0 and re-enter BR_UP on reaching 0; done SHALL NOT pulse in breathe mode.
REQ-026 SHALL, on a command accepted during BR_UP or BR_DOWN, abandon breathing and start from the current level.

Reset
REQ-027 SHALL, while rst=1, set state=IDLE, level=0, period_cnt=0, target=0, step=0, pwm_en=0, dutycycle=11'h7FF, busy=0, done=0 and cmd_ready=0.
REQ-028 SHALL, on reset mid-ramp or mid-breathe, force level to 0 at the next edge with no done pulse, and drive cmd_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-029 SHALL compile BR_UP, BR_DOWN and the mode-1 decode only when LED_FADE_BREATHE_EN is defined.
REQ-030 SHALL, without LED_FADE_BREATHE_EN, keep the cmd_mode port, ignore its value, and treat every command as mode 0.

Verification
REQ-031 SHALL cover: reset, then cmd target=100, step=50, mode=0 -> level 50 and pwm_en=1 one tick after accept; level 100, done pulse, busy=0 2048 cycles later.
REQ-032 SHALL cover: from level 100, cmd target=0, step=0 -> level 0, pwm_en=0, dutycycle=0x7FF at the next period boundary; done pulses.
REQ-033 SHALL cover: level=2000, cmd target=2047, step=255 -> level saturates at 2047 (dutycycle=1) with no wrap.
REQ-034 SHALL cover: cmd_valid held during RAMP -> cmd_ready=0 and no accept until done; the command is accepted on the first IDLE cycle.
REQ-035 SHALL cover (macro defined): mode=1, target=8, step=4 -> level sequence 4, 8, 4, 0, 4, ... on ticks; a new mode-0 command exits breathing.
REQ-036 SHALL cover: rst asserted mid-ramp at level 60 -> all outputs at reset values on the next edge; no done pulse.
